// File: rtl/recirc_ctrl.sv
// recirc_ctrl: sequencing controller for the four-lane recirculation demux.
// Drives the demux select (IDLE_OUT), runs the RESET/INIT/IDLE/ACTIVE/ERROR
// link state machine, latches the FIFO thresholds during INIT and keeps a
// sticky per-lane record of FIFO errors.
// Optional feature: define RECIRC_TIMEOUT_EN to add a recirculation watchdog
// that forces ERROR after TIMEOUT consecutive recirculating ACTIVE cycles.
module recirc_ctrl #(
    parameter logic [2:0] UMBRAL_ALTO_RST = 3'd6,
    parameter logic [2:0] UMBRAL_BAJO_RST = 3'd1,
    parameter logic [7:0] TIMEOUT         = 8'd255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       init,
    input  logic [2:0] umbral_alto_in,
    input  logic [2:0] umbral_bajo_in,
    input  logic [3:0] fifo_empty,
    input  logic [3:0] fifo_almost_full,
    input  logic [3:0] fifo_error,
    output logic       IDLE_OUT,
    output logic       active_out,
    output logic       idle_out_st,
    output logic       error_out,
    output logic [2:0] state,
    output logic [2:0] umbral_alto_out,
    output logic [2:0] umbral_bajo_out,
    output logic [3:0] error_lane
);

    typedef enum logic [2:0] {
        ST_RESET  = 3'd0,
        ST_INIT   = 3'd1,
        ST_IDLE   = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_ERROR  = 3'd4
    } state_t;

    state_t state_q;
    state_t next_state;
    logic   pass_next;
    logic   timeout_hit;

`ifdef RECIRC_TIMEOUT_EN
    logic [7:0] wdog_cnt;

    assign timeout_hit = (state_q == ST_ACTIVE) && (wdog_cnt == TIMEOUT);

    // Count consecutive ACTIVE cycles spent recirculating; saturates at all-ones
    always_ff @(posedge clk) begin
        if (reset) begin
            wdog_cnt <= 8'd0;
        end else if ((state_q == ST_ACTIVE) && !IDLE_OUT) begin
            if (wdog_cnt != 8'hFF) begin
                wdog_cnt <= wdog_cnt + 8'd1;
            end
        end else begin
            wdog_cnt <= 8'd0;
        end
    end
`else
    logic unused_timeout;

    assign timeout_hit    = 1'b0;
    assign unused_timeout = ^TIMEOUT;
`endif

    // Next-state selection; within a state, errors win over init, init over the rest
    always_comb begin
        next_state = state_q;
        case (state_q)
            ST_RESET: begin
                next_state = ST_INIT;
            end
            ST_INIT: begin
                next_state = init ? ST_INIT : ST_IDLE;
            end
            ST_IDLE: begin
                if (|fifo_error) begin
                    next_state = ST_ERROR;
                end else if (init) begin
                    next_state = ST_INIT;
                end else if (fifo_empty != 4'hF) begin
                    next_state = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if ((|fifo_error) || timeout_hit) begin
                    next_state = ST_ERROR;
                end else if (init) begin
                    next_state = ST_INIT;
                end else if (fifo_empty == 4'hF) begin
                    next_state = ST_IDLE;
                end
            end
            ST_ERROR: begin
                next_state = ST_ERROR;
            end
            default: begin
                next_state = ST_RESET;
            end
        endcase
    end

    // Data may pass only when heading to IDLE, or to ACTIVE with no FIFO near full
    always_comb begin
        pass_next = (next_state == ST_IDLE) ||
                    ((next_state == ST_ACTIVE) && (fifo_almost_full == 4'b0000));
    end

    // State register, registered decodes of next_state, thresholds and error capture
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= ST_RESET;
            IDLE_OUT        <= 1'b0;
            active_out      <= 1'b0;
            idle_out_st     <= 1'b0;
            error_out       <= 1'b0;
            umbral_alto_out <= UMBRAL_ALTO_RST;
            umbral_bajo_out <= UMBRAL_BAJO_RST;
            error_lane      <= 4'b0000;
        end else begin
            state_q     <= next_state;
            IDLE_OUT    <= pass_next;
            active_out  <= (next_state == ST_ACTIVE);
            idle_out_st <= (next_state == ST_IDLE);
            error_out   <= (next_state == ST_ERROR);
            if (state_q == ST_INIT) begin
                umbral_alto_out <= umbral_alto_in;
                umbral_bajo_out <= umbral_bajo_in;
            end
            if ((state_q == ST_IDLE) || (state_q == ST_ACTIVE)) begin
                error_lane <= error_lane | fifo_error;
            end
        end
    end

    assign state = state_q;

endmodule
